pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 4, meaning register-address width (2**REG_AW architectural registers).
REQ-002 SHALL have parameter LOAD_STALL, default 1, meaning data-memory load latency in stages; legal values 1 or 2.
REQ-003 SHALL have parameter ZERO_REG_HW, default 0, meaning 1 = register 0 is hardwired and never forwarded or stalled on.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports id_valid, id_rs1_used, id_rs2_used  input  1 each  ID instruction valid; source 1 read; source 2 read.
REQ-007 SHALL have ports id_rs1, id_rs2  input  REG_AW each  ID source register addresses.
REQ-008 SHALL have ports id_wr1_en, id_wr2_en  input  1 each  ID instruction writes the LO result half; writes the HI result half (dual-write ops).
REQ-009 SHALL have ports id_wr1_reg, id_wr2_reg  input  REG_AW each  ID destination registers for the LO and HI halves.
REQ-010 SHALL have ports id_is_load, id_halt  input  1 each  ID instruction is a load; ID instruction is halt.
REQ-011 SHALL have port ex_br_taken  input  1  branch or jump resolved taken in EX this cycle.
REQ-012 SHALL have port stall  output  1  hold PC and IF/ID.
REQ-013 SHALL have port flush_ifid  output  1  clear IF/ID to a bubble.
REQ-014 SHALL have port bubble_idex  output  1  load a bubble into ID/EX.
REQ-015 SHALL have ports fwd_a, fwd_b  output  3 each  operand source select: 0 RF, 1 EX_LO, 2 EX_HI, 3 MEM_LO, 4 MEM_HI, 5 WB_LO, 6 WB_HI.
REQ-016 SHALL have port halted  output  1  pipeline drained after halt.

Function
REQ-017 SHALL keep a tag (valid, wr1_en, wr1_reg, wr2_en, wr2_reg, is_load) for each of the EX, MEM and WB stages; the tags shift EX->MEM->WB every cycle.
REQ-018 SHALL load the EX tag from the ID inputs when bubble_idex=0 and with an invalid tag when bubble_idex=1; MEM and WB never stall.
REQ-019 SHALL compute forwarding per operand combinationally, youngest first: EX, then MEM, then WB; within a stage, LO beats HI when both match.
REQ-020 SHALL let a stage match only when its tag is valid, the write enable is set, the register equals the source, and the source-used bit is set; with ZERO_REG_HW=1, source 0 never matches.
REQ-021 SHALL never forward a load result from a stage of index below LOAD_STALL (EX=0, MEM=1, WB=2).
REQ-022 SHALL assert stall and bubble_idex (load-use) while id_valid=1 and an operand's youngest match is a load in a stage of index below LOAD_STALL.
REQ-023 SHALL, on ex_br_taken=1 in RUN, assert flush_ifid=1 and bubble_idex=1, force stall=0, and override any load-use stall or halt in ID that cycle.
REQ-024 SHALL implement the FSM RUN, DRAIN and HALTED, moving RUN->DRAIN when id_valid=1, id_halt=1 and ex_br_taken=0.
REQ-025 SHALL, in DRAIN, hold stall=1 and bubble_idex=1 and ignore ex_br_taken, moving to HALTED once the EX, MEM and WB tags are all invalid.
REQ-026 SHALL, in HALTED, drive halted=1, stall=1 and bubble_idex=1, and stay there until rst.
REQ-027 SHALL keep fwd_a and fwd_b purely tag-derived, so that WB forwarding covers a register-file write in the same cycle.

Reset
REQ-028 SHALL, while rst=1, immediately clear all tags to invalid, set the FSM to RUN, and drive stall=0, flush_ifid=0, bubble_idex=0, fwd_a=fwd_b=0 and halted=0.
REQ-029 SHALL, on rst asserted mid-DRAIN or mid-stall, abandon that operation with no residual stall after release.

Structure
REQ-030 SHALL place the fwd source codes, the FSM state encoding and the stage-tag record type in the shared package cpu_pipe_pkg.
REQ-031 SHALL build each tag stage from one sub-module pipe_tag_stage (a register with a bubble-load input), instantiated three times.

Verification
REQ-032 SHALL test back-to-back ALU ops (R3 written, then read as rs1): expect fwd_a=1, then fwd_a=3 and fwd_a=5 over the next cycles with later readers, and stall=0 throughout.
REQ-033 SHALL test a load to R5 followed by a reader of R5, LOAD_STALL=1: expect one cycle stall=1 and bubble_idex=1, then fwd=3; with LOAD_STALL=2, expect two stall cycles, then fwd=5.
REQ-034 SHALL test a dual-write op to R2/R3 followed by readers of R2 and R3: expect fwd_a=1 and fwd_b=2; with wr1_reg=wr2_reg=R2, expect fwd_a=1.
REQ-035 SHALL test ex_br_taken=1 coincident with a load-use hazard and a halt in ID: expect flush_ifid=1, stall=0, FSM remains RUN.
REQ-036 SHALL test halt in ID with a valid MEM/WB: expect halted=1 exactly when the last valid tag leaves WB; rst then clears halted=0 asynchronously.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared types for the pipeline hazard unit.
// Holds the operand-forwarding source codes, the hazard FSM state encoding
// and the per-stage destination tag record that travels EX -> MEM -> WB.
package cpu_pipe_pkg;

    // Tag register fields are sized for the widest supported register file;
    // narrower REG_AW values are zero-extended into them (REG_AW <= TAG_AW).
    localparam int TAG_AW = 8;

    typedef enum logic [2:0] {
        FWD_RF     = 3'd0,
        FWD_EX_LO  = 3'd1,
        FWD_EX_HI  = 3'd2,
        FWD_MEM_LO = 3'd3,
        FWD_MEM_HI = 3'd4,
        FWD_WB_LO  = 3'd5,
        FWD_WB_HI  = 3'd6
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic              valid;
        logic              wr1_en;
        logic [TAG_AW-1:0] wr1_reg;
        logic              wr2_en;
        logic [TAG_AW-1:0] wr2_reg;
        logic              is_load;
    } stage_tag_t;

    // Codes run LO/HI per stage in age order, so the code is a simple
    // function of stage index (EX=0, MEM=1, WB=2) and result half.
    function automatic fwd_sel_e fwd_code(input int stage, input logic hi);
        return fwd_sel_e'(3'(1 + 2 * stage + (hi ? 1 : 0)));
    endfunction

endpackage

// File: rtl/pipe_tag_stage.sv
// One pipeline-stage destination tag register.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, clears the tag to invalid
//   bubble_i - load an invalid tag instead of tag_i
//   tag_i    - tag from the previous stage
//   tag_o    - registered tag for this stage
module pipe_tag_stage
    import cpu_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bubble_i,
    input  stage_tag_t tag_i,
    output stage_tag_t tag_o
);

    stage_tag_t tag_d;
    stage_tag_t tag_q;

    always_comb begin
        tag_d = bubble_i ? stage_tag_t'('0) : tag_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_o = tag_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// halt drain for a 5-stage pipeline with dual-write (LO/HI) instructions.
// Ports:
//   clk, rst                      - clock; asynchronous active-high reset
//   id_valid, id_rs1/2_used       - ID instruction valid and source-read flags
//   id_rs1, id_rs2                - ID source register addresses
//   id_wr1_en/reg, id_wr2_en/reg  - ID LO/HI destination writes
//   id_is_load, id_halt           - ID instruction is a load / halt
//   ex_br_taken                   - branch resolved taken in EX
//   stall                         - hold PC and IF/ID
//   flush_ifid                    - clear IF/ID to a bubble
//   bubble_idex                   - load a bubble into ID/EX
//   fwd_a, fwd_b                  - operand source select (fwd_sel_e codes)
//   halted                        - pipeline drained after halt
module pipe_hazard_unit
    import cpu_pipe_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter int LOAD_STALL  = 1,
    parameter int ZERO_REG_HW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_wr1_en,
    input  logic              id_wr2_en,
    input  logic [REG_AW-1:0] id_wr1_reg,
    input  logic [REG_AW-1:0] id_wr2_reg,
    input  logic              id_is_load,
    input  logic              id_halt,
    input  logic              ex_br_taken,
    output logic              stall,
    output logic              flush_ifid,
    output logic              bubble_idex,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
    output logic              halted
);

    hz_state_e  state_q, state_d;
    stage_tag_t id_tag;
    stage_tag_t ex_tag_q, mem_tag_q, wb_tag_q;
    logic [3:0] res_a, res_b;
    logic       load_use;

    always_comb begin
        id_tag         = '0;
        id_tag.valid   = id_valid;
        id_tag.wr1_en  = id_wr1_en;
        id_tag.wr1_reg = TAG_AW'(id_wr1_reg);
        id_tag.wr2_en  = id_wr2_en;
        id_tag.wr2_reg = TAG_AW'(id_wr2_reg);
        id_tag.is_load = id_is_load;
    end

    pipe_tag_stage u_ex_tag (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (bubble_idex),
        .tag_i    (id_tag),
        .tag_o    (ex_tag_q)
    );

    pipe_tag_stage u_mem_tag (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .tag_i    (ex_tag_q),
        .tag_o    (mem_tag_q)
    );

    pipe_tag_stage u_wb_tag (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .tag_i    (mem_tag_q),
        .tag_o    (wb_tag_q)
    );

    // Returns {load_use_hazard, fwd_code}. Only the youngest matching stage
    // decides; if that stage holds a load whose data is not ready yet the
    // operand cannot be forwarded from any older stage either, so the code
    // falls back to RF and the hazard bit requests a stall.
    function automatic logic [3:0] resolve(input logic used,
                                           input logic [REG_AW-1:0] src,
                                           input stage_tag_t t0,
                                           input stage_tag_t t1,
                                           input stage_tag_t t2);
        stage_tag_t        t;
        logic [TAG_AW-1:0] s;
        logic              lo, hi, done, src_ok;
        logic [3:0]        r;
        r      = 4'd0;
        done   = 1'b0;
        s      = TAG_AW'(src);
        src_ok = used && !((ZERO_REG_HW != 0) && (src == '0));
        for (int i = 0; i < 3; i++) begin
            t  = (i == 0) ? t0 : ((i == 1) ? t1 : t2);
            lo = t.valid && t.wr1_en && (t.wr1_reg == s);
            hi = t.valid && t.wr2_en && (t.wr2_reg == s);
            if (!done && src_ok && (lo || hi)) begin
                done = 1'b1;
                if (t.is_load && (i < LOAD_STALL)) begin
                    r = {1'b1, FWD_RF};
                end else begin
                    r = {1'b0, fwd_code(i, !lo)};
                end
            end
        end
        return r;
    endfunction

    assign res_a    = resolve(id_rs1_used, id_rs1, ex_tag_q, mem_tag_q, wb_tag_q);
    assign res_b    = resolve(id_rs2_used, id_rs2, ex_tag_q, mem_tag_q, wb_tag_q);
    assign load_use = id_valid && (res_a[3] || res_b[3]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        halted      = 1'b0;
        fwd_a       = res_a[2:0];
        fwd_b       = res_b[2:0];
        case (state_q)
            ST_RUN: begin
                // A taken branch kills whatever sits in ID, so neither its
                // load-use hazard nor its halt may take effect.
                if (ex_br_taken) begin
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end else begin
                    if (load_use) begin
                        stall       = 1'b1;
                        bubble_idex = 1'b1;
                    end
                    if (id_valid && id_halt) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                stall       = 1'b1;
                bubble_idex = 1'b1;
                // EX always refills with a bubble here, so once EX and MEM
                // are empty the WB tag leaves on this edge and all three
                // stages are empty as HALTED is entered.
                if (!ex_tag_q.valid && !mem_tag_q.valid) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                stall       = 1'b1;
                bubble_idex = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (rst) begin
            state_d     = ST_RUN;
            stall       = 1'b0;
            flush_ifid  = 1'b0;
            bubble_idex = 1'b0;
            halted      = 1'b0;
            fwd_a       = 3'd0;
            fwd_b       = 3'd0;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: dut1 uses LOAD_STALL=1, dut2 uses LOAD_STALL=2
// with register 0 hardwired. Each step drives one ID instruction and pushes
// the expected outputs for that cycle; a negedge checker pops and compares.
module tb_pipe_hazard_unit;

    typedef struct packed {
        logic       valid;
        logic       u1;
        logic [3:0] rs1;
        logic       u2;
        logic [3:0] rs2;
        logic       w1;
        logic [3:0] wr1;
        logic       w2;
        logic [3:0] wr2;
        logic       ld;
        logic       halt;
        logic       br;
    } in_t;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic       bubble;
        logic [2:0] fa;
        logic [2:0] fb;
        logic       halted;
    } out_t;

    typedef struct {
        in_t   in;
        out_t  exp;
        string name;
    } vec_t;

    typedef struct {
        int    which;
        out_t  exp;
        string name;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    in_t  v1 = '0;
    in_t  v2 = '0;
    out_t o1, o2;
    int   total = 0;
    int   bad = 0;
    sb_t  sbq[$];
    vec_t tbl[$];

    logic       s1, f1, b1, h1, s2, f2, b2, h2;
    logic [2:0] fa1, fb1, fa2, fb2;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.REG_AW(4), .LOAD_STALL(1), .ZERO_REG_HW(0)) dut1 (
        .clk(clk), .rst(rst),
        .id_valid(v1.valid), .id_rs1_used(v1.u1), .id_rs2_used(v1.u2),
        .id_rs1(v1.rs1), .id_rs2(v1.rs2),
        .id_wr1_en(v1.w1), .id_wr2_en(v1.w2),
        .id_wr1_reg(v1.wr1), .id_wr2_reg(v1.wr2),
        .id_is_load(v1.ld), .id_halt(v1.halt), .ex_br_taken(v1.br),
        .stall(s1), .flush_ifid(f1), .bubble_idex(b1),
        .fwd_a(fa1), .fwd_b(fb1), .halted(h1)
    );

    pipe_hazard_unit #(.REG_AW(4), .LOAD_STALL(2), .ZERO_REG_HW(1)) dut2 (
        .clk(clk), .rst(rst),
        .id_valid(v2.valid), .id_rs1_used(v2.u1), .id_rs2_used(v2.u2),
        .id_rs1(v2.rs1), .id_rs2(v2.rs2),
        .id_wr1_en(v2.w1), .id_wr2_en(v2.w2),
        .id_wr1_reg(v2.wr1), .id_wr2_reg(v2.wr2),
        .id_is_load(v2.ld), .id_halt(v2.halt), .ex_br_taken(v2.br),
        .stall(s2), .flush_ifid(f2), .bubble_idex(b2),
        .fwd_a(fa2), .fwd_b(fb2), .halted(h2)
    );

    assign o1 = {s1, f1, b1, fa1, fb1, h1};
    assign o2 = {s2, f2, b2, fa2, fb2, h2};

    function automatic in_t alu(input logic [3:0] w);
        in_t v = '0;
        v.valid = 1'b1; v.w1 = 1'b1; v.wr1 = w;
        return v;
    endfunction

    function automatic in_t dual(input logic [3:0] a, input logic [3:0] b);
        in_t v = '0;
        v.valid = 1'b1; v.w1 = 1'b1; v.wr1 = a; v.w2 = 1'b1; v.wr2 = b;
        return v;
    endfunction

    function automatic in_t load(input logic [3:0] w);
        in_t v = '0;
        v.valid = 1'b1; v.w1 = 1'b1; v.wr1 = w; v.ld = 1'b1;
        return v;
    endfunction

    function automatic in_t rd(input logic u1, input logic [3:0] r1,
                               input logic u2, input logic [3:0] r2);
        in_t v = '0;
        v.valid = 1'b1; v.u1 = u1; v.rs1 = r1; v.u2 = u2; v.rs2 = r2;
        return v;
    endfunction

    function automatic out_t X(input logic st, input logic fl, input logic bu,
                               input logic [2:0] a, input logic [2:0] b,
                               input logic ha);
        out_t o;
        o.stall = st; o.flush = fl; o.bubble = bu; o.fa = a; o.fb = b; o.halted = ha;
        return o;
    endfunction

    function automatic void add(input in_t v, input out_t e, input string nm);
        vec_t t;
        t.in = v; t.exp = e; t.name = nm;
        tbl.push_back(t);
    endfunction

    function automatic void chk(input int which, input out_t e, input string nm);
        out_t a;
        a = (which == 2) ? o2 : o1;
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s dut%0d: got stall=%b flush=%b bubble=%b fwd_a=%0d fwd_b=%0d halted=%b, want stall=%b flush=%b bubble=%b fwd_a=%0d fwd_b=%0d halted=%b",
                     nm, which, a.stall, a.flush, a.bubble, a.fa, a.fb, a.halted,
                     e.stall, e.flush, e.bubble, e.fa, e.fb, e.halted);
        end
    endfunction

    // Drive one ID cycle on one DUT (the other idles) and queue its expectation.
    task automatic step(input int which, input in_t v, input out_t e, input string nm);
        sb_t s;
        @(posedge clk);
        #1;
        if (which == 2) begin
            v2 = v; v1 = '0;
        end else begin
            v1 = v; v2 = '0;
        end
        s.which = which; s.exp = e; s.name = nm;
        sbq.push_back(s);
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            sb_t s;
            s = sbq.pop_front();
            chk(s.which, s.exp, s.name);
        end
    end

    initial begin
        in_t  v;
        out_t z;
        z = '0;

        // Table: dut1, LOAD_STALL=1
        add(alu(3),           z,                  "alu_w3");
        add(rd(1, 3, 0, 0),   X(0, 0, 0, 1, 0, 0), "fwd_ex_lo");
        add(rd(1, 3, 0, 0),   X(0, 0, 0, 3, 0, 0), "fwd_mem_lo");
        add(rd(1, 3, 0, 0),   X(0, 0, 0, 5, 0, 0), "fwd_wb_lo");
        add(rd(1, 3, 0, 0),   z,                  "fwd_rf");
        add(load(5),          z,                  "load_w5");
        add(rd(1, 5, 1, 5),   X(1, 0, 1, 0, 0, 0), "ld_use_stall");
        add(rd(1, 5, 1, 5),   X(0, 0, 0, 3, 3, 0), "ld_use_fwd_mem");
        add(dual(2, 3),       z,                  "dual_w23");
        add(rd(1, 2, 1, 3),   X(0, 0, 0, 1, 2, 0), "dual_lo_hi");
        add(dual(2, 2),       z,                  "dual_w22");
        add(rd(1, 2, 1, 2),   X(0, 0, 0, 1, 1, 0), "dual_same_reg");
        add(rd(0, 2, 1, 2),   X(0, 0, 0, 0, 3, 0), "rs1_unused");
        add(alu(7),           z,                  "alu_w7a");
        add(alu(7),           z,                  "alu_w7b");
        add(rd(1, 7, 0, 0),   X(0, 0, 0, 1, 0, 0), "ex_beats_mem");
        add(rd(0, 0, 1, 7),   X(0, 0, 0, 0, 3, 0), "fwd_b_mem");
        add(dual(8, 9),       z,                  "dual_w89");
        add('0,               z,                  "nop");
        add(rd(1, 9, 1, 8),   X(0, 0, 0, 4, 3, 0), "fwd_mem_hi");
        add(rd(1, 9, 1, 8),   X(0, 0, 0, 6, 5, 0), "fwd_wb_hi");
        add(load(4),          z,                  "load_w4");
        v = rd(1, 4, 0, 0); v.valid = 1'b0;
        add(v,                z,                  "ld_invalid_id");
        add(rd(1, 4, 0, 0),   X(0, 0, 0, 3, 0, 0), "ld_fwd_no_stall");
        add(alu(0),           z,                  "alu_w0");
        add(rd(1, 0, 0, 0),   X(0, 0, 0, 1, 0, 0), "r0_fwd");

        // Reset state, with inputs that would otherwise flush/stall.
        #1;
        rst = 1'b1;
        v = rd(1, 5, 1, 5); v.halt = 1'b1; v.br = 1'b1;
        v1 = v; v2 = v;
        #1;
        chk(1, z, "reset_dut1");
        chk(2, z, "reset_dut2");
        @(negedge clk);
        rst = 1'b0;
        v1 = '0; v2 = '0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(1, tbl[i].in, tbl[i].exp, tbl[i].name);
        end

        // Branch taken coincident with load-use and halt in ID.
        step(1, load(6), z, "br_load_w6");
        v = rd(1, 6, 0, 0); v.halt = 1'b1; v.br = 1'b1;
        step(1, v, X(0, 1, 1, 0, 0, 0), "br_overrides");
        step(1, '0, z, "br_stays_run");
        step(1, rd(1, 6, 0, 0), X(0, 0, 0, 5, 0, 0), "br_post_fwd_wb");

        // Halt with valid MEM/WB, drain, then asynchronous reset.
        step(1, alu(1), z, "pre_halt_w1");
        step(1, alu(2), z, "pre_halt_w2");
        v = '0; v.valid = 1'b1; v.halt = 1'b1;
        step(1, v, z, "halt_in_id");
        step(1, '0, X(1, 0, 1, 0, 0, 0), "drain1");
        v = '0; v.br = 1'b1;
        step(1, v, X(1, 0, 1, 0, 0, 0), "drain_ignores_br");
        step(1, '0, X(1, 0, 1, 0, 0, 0), "drain_wb_last");
        step(1, '0, X(1, 0, 1, 0, 0, 1), "halted");
        step(1, '0, X(1, 0, 1, 0, 0, 1), "halted_hold");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk(1, z, "rst_clears_halted");
        #1;
        rst = 1'b0;
        step(1, '0, z, "after_rst_run");

        // Reset in the middle of a load-use stall.
        step(1, load(5), z, "pre_rst_load");
        step(1, rd(1, 5, 0, 0), X(1, 0, 1, 0, 0, 0), "stall_before_rst");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk(1, z, "rst_during_stall");
        #1;
        rst = 1'b0;
        step(1, rd(1, 5, 0, 0), z, "no_residual_stall");

        // dut2: LOAD_STALL=2, register 0 hardwired.
        step(2, load(5), z, "ls2_load");
        step(2, rd(1, 5, 0, 0), X(1, 0, 1, 0, 0, 0), "ls2_stall1");
        step(2, rd(1, 5, 0, 0), X(1, 0, 1, 0, 0, 0), "ls2_stall2");
        step(2, rd(1, 5, 0, 0), X(0, 0, 0, 5, 0, 0), "ls2_fwd_wb");
        step(2, alu(0), z, "zr_alu_w0");
        step(2, rd(1, 0, 0, 0), z, "zero_reg_no_fwd");
        step(2, load(0), z, "zr_load_w0");
        step(2, rd(1, 0, 0, 0), z, "zero_reg_no_stall");

        @(posedge clk);
        #1;
        v1 = '0; v2 = '0;
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
